// File: rtl/irrigation_zone_scheduler_if.sv
// Pump/valve scheduler bus: zone requests in, pump/valve/status out.
// master drives requests and rain; slave is the scheduler.
interface irrigation_zone_scheduler_if #(
  parameter int NUM_ZONES = 4,
  parameter int TIME_W    = 8
);
  localparam int AW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

  logic [NUM_ZONES-1:0]        zone_req;
  logic [NUM_ZONES*TIME_W-1:0] zone_time;
  logic                        rain_present;
  logic                        pump_on;
  logic [NUM_ZONES-1:0]        valve_sel;
  logic [AW-1:0]               active_zone;
  logic [TIME_W-1:0]           watering_timer;
  logic                        watering_in_progress;
  logic                        sensor_enable;
  logic [NUM_ZONES-1:0]        zone_done;
  logic                        rain_abort;

  modport master (
    output zone_req, zone_time, rain_present,
    input  pump_on, valve_sel, active_zone, watering_timer,
    input  watering_in_progress, sensor_enable, zone_done, rain_abort
  );

  modport slave (
    input  zone_req, zone_time, rain_present,
    output pump_on, valve_sel, active_zone, watering_timer,
    output watering_in_progress, sensor_enable, zone_done, rain_abort
  );
endinterface

// File: rtl/irrigation_zone_scheduler.sv
// Round-robin pump sharing across zones: OPEN -> WATER -> CLOSE per grant.
// Optional macro SCHED_MAX_TIME_EN clamps each grant to MAX_SECONDS.
module irrigation_zone_scheduler #(
  parameter int NUM_ZONES   = 4,
  parameter int TIME_W      = 8,
  parameter int TICK_DIV    = 50,
  parameter int SETTLE_CYC  = 4,
  parameter int MAX_SECONDS = 120
) (
  input logic                          clk,
  input logic                          reset,
  irrigation_zone_scheduler_if.slave   bus
);
  localparam int AW = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_OPEN, S_WATER, S_CLOSE
  } state_e;

  state_e               state_q, state_d;
  logic [AW-1:0]        last_q, last_d;
  logic [AW-1:0]        active_q, active_d;
  logic [TIME_W-1:0]    time_q, time_d;
  logic [TIME_W-1:0]    timer_q, timer_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [SW-1:0]        settle_q, settle_d;
  logic                 abrt_q, abrt_d;
  logic [NUM_ZONES-1:0] done_q, done_d;
  logic                 rab_q, rab_d;
  logic                 pump_q;
  logic [NUM_ZONES-1:0] valve_q, valve_d;
  logic                 wip_q;
  logic                 sens_q;

  logic                 gnt_ok;
  logic [AW-1:0]        gnt_idx;
  logic [AW-1:0]        cand;
  logic [TIME_W-1:0]    req_time;
  logic [TIME_W-1:0]    lat_time;

  // Pick first requester after last grant; lowest offset wins.
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_ZONES; k >= 1; k--) begin
      cand = AW'((int'(last_q) + k) % NUM_ZONES);
      if (bus.zone_req[cand]) begin
        gnt_ok  = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign req_time = bus.zone_time[gnt_idx*TIME_W +: TIME_W];

`ifdef SCHED_MAX_TIME_EN
  assign lat_time = (int'(req_time) > MAX_SECONDS)
                  ? TIME_W'(MAX_SECONDS) : req_time;
`else
  logic unused_max;
  assign unused_max = (MAX_SECONDS != 0);
  assign lat_time   = req_time;
`endif

  // Next-state: grant, settle, timed watering, rain abort.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    active_d = active_q;
    time_d   = time_q;
    timer_d  = timer_q;
    tick_d   = tick_q;
    settle_d = settle_q;
    abrt_d   = abrt_q;
    done_d   = '0;
    rab_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!bus.rain_present && gnt_ok) begin
          last_d   = gnt_idx;
          active_d = gnt_idx;
          time_d   = lat_time;
          abrt_d   = 1'b0;
          settle_d = '0;
          if (lat_time == '0) done_d[gnt_idx] = 1'b1;
          else                state_d = S_OPEN;
        end
      end
      S_OPEN: begin
        if (bus.rain_present) begin
          state_d  = S_CLOSE;
          abrt_d   = 1'b1;
          settle_d = '0;
        end else if (settle_q == SW'(SETTLE_CYC-1)) begin
          state_d = S_WATER;
          timer_d = time_q;
          tick_d  = '0;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_WATER: begin
        if (bus.rain_present) begin
          state_d  = S_CLOSE;
          abrt_d   = 1'b1;
          settle_d = '0;
        end else if (tick_q == TW'(TICK_DIV-1)) begin
          tick_d = '0;
          if (timer_q != '0) timer_d = timer_q - TIME_W'(1);
          if (timer_q <= TIME_W'(1)) begin
            state_d  = S_CLOSE;
            settle_d = '0;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
      S_CLOSE: begin
        if (settle_q == SW'(SETTLE_CYC-1)) begin
          state_d = S_IDLE;
          if (abrt_q) rab_d = 1'b1;
          else        done_d[active_q] = 1'b1;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Valve follows the next state so it opens with the grant.
  always_comb begin
    valve_d = '0;
    if (state_d != S_IDLE) valve_d[active_d] = 1'b1;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      last_q   <= AW'(NUM_ZONES-1);
      active_q <= '0;
      time_q   <= '0;
      timer_q  <= '0;
      tick_q   <= '0;
      settle_q <= '0;
      abrt_q   <= 1'b0;
      done_q   <= '0;
      rab_q    <= 1'b0;
      pump_q   <= 1'b0;
      valve_q  <= '0;
      wip_q    <= 1'b0;
      sens_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      active_q <= active_d;
      time_q   <= time_d;
      timer_q  <= timer_d;
      tick_q   <= tick_d;
      settle_q <= settle_d;
      abrt_q   <= abrt_d;
      done_q   <= done_d;
      rab_q    <= rab_d;
      pump_q   <= (state_d == S_WATER);
      valve_q  <= valve_d;
      wip_q    <= (state_d != S_IDLE);
      sens_q   <= (state_d == S_IDLE);
    end
  end

  assign bus.pump_on              = pump_q;
  assign bus.valve_sel            = valve_q;
  assign bus.active_zone          = active_q;
  assign bus.watering_timer       = timer_q;
  assign bus.watering_in_progress = wip_q;
  assign bus.sensor_enable        = sens_q;
  assign bus.zone_done            = done_q;
  assign bus.rain_abort           = rab_q;
endmodule
